fifo_rd_stream: RTL and testbench

Read-side adapter for the team's `async_fifo`: operates in the read-clock domain, drives the FIFO's `rd_en`, absorbs its one-cycle registered read latency, and presents the popped words as a valid/ready stream to downstream logic. A 2-entry output buffer sustains one word per cycle under continuous `m_ready` and loses nothing under back-pressure. A transfer counter and a `busy` flag support drain detection.

---
 rtl/fifo_rd_stream.sv | 90 +++++++++
 tb/tb_fifo_rd_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream: async_fifo read-side adapter, rd_en credit + 2-entry stream buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  deq;
  logic [2:0]            need;
  logic [2:0]            room;
  logic                  credit_ok;

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = head_q;
  assign word_cnt = cnt_q;
  assign busy     = m_valid | inflight_q;
  assign deq      = m_valid & m_ready;

  // A new pop needs a slot after accounting for the word already in flight
  // and the head that leaves this cycle.
  always_comb begin
    need      = {1'b0, occ_q} + {2'b00, inflight_q} + 3'd1;
    room      = 3'd2 + {2'b00, deq};
    credit_ok = (need <= room);
  end

  assign fifo_rd_en = rst_n & enable & ~fifo_empty & credit_ok;
  assign inflight_d = fifo_rd_en;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q - {1'b0, deq} + {1'b0, inflight_q};
    cnt_d  = cnt_q + CNT_WIDTH'(deq);

    if (deq && (occ_q == 2'd2)) begin
      head_d = tail_q;
    end

    if (inflight_q) begin
      if ((occ_q == 2'd0) || (deq && (occ_q == 2'd1))) begin
        head_d = fifo_dout;
      end else begin
        // occ=1 holding, or occ=2 shifting: the new word lands behind the head
        tail_d = fifo_dout;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_stream: directed bench with a queue-based stream model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       m_ready;
  logic       force_empty;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;

  logic        fifo_rd_en, m_valid, busy;
  logic [7:0]  m_data;
  logic [15:0] word_cnt;
  logic        rd_en4, m_valid4, busy4;
  logic [7:0]  m_data4;
  logic [3:0]  word_cnt4;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .word_cnt(word_cnt), .busy(busy)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(rd_en4), .m_valid(m_valid4),
    .m_ready(m_ready), .m_data(m_data4), .word_cnt(word_cnt4), .busy(busy4)
  );

  // FIFO model: registered read data, one word per pop
  logic [7:0] fmem [0:511];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fmem[rd_ptr[8:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stream model: words become visible two edges after their pop
  logic [7:0] avail[$];
  logic [7:0] acc_log[$];
  bit         infl;
  logic [7:0] infl_val;
  int         cnt_m;
  int         m_occ;
  bit         n_deq, n_pop, exp_rd;
  logic [7:0] n_val;

  initial begin
    infl  = 0;
    cnt_m = 0;
    n_deq = 0;
    n_pop = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        avail.delete();
        acc_log.delete();
        infl  = 0;
        cnt_m = 0;
        n_deq = 0;
        n_pop = 0;
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 0);
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_data", {24'd0, m_data}, 0);
        chk("rst_cnt", {16'd0, word_cnt}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_cnt4", {28'd0, word_cnt4}, 0);
      end else begin
        m_occ  = avail.size();
        n_deq  = (m_occ != 0) && m_ready;
        exp_rd = enable && !fifo_empty && (m_occ + int'(infl) - int'(n_deq) + 1 <= 2);
        chk("m_valid", {31'd0, m_valid}, {31'd0, m_occ != 0});
        if (m_occ != 0) chk("m_data", {24'd0, m_data}, {24'd0, avail[0]});
        chk("rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
        chk("busy", {31'd0, busy}, {31'd0, (m_occ != 0) || infl});
        chk("word_cnt", {16'd0, word_cnt}, {16'd0, cnt_m[15:0]});
        chk("word_cnt4", {28'd0, word_cnt4}, {28'd0, cnt_m[3:0]});
        chk("dut4_match", {22'd0, rd_en4, m_valid4, busy4, m_data4},
            {22'd0, fifo_rd_en, m_valid, busy, m_data});
        n_pop = exp_rd;
        n_val = fmem[rd_ptr[8:0]];
      end
      @(posedge clk);
      if (rst_n) begin
        if (n_deq) begin
          acc_log.push_back(avail[0]);
          void'(avail.pop_front());
          cnt_m++;
        end
        if (infl) avail.push_back(infl_val);
        infl     = n_pop;
        infl_val = n_val;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_ptr[8:0]] = 8'(base + i);
      wr_ptr++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    wr_ptr = rd_ptr;
    tick();
    tick();
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (fifo_empty && !busy) break;
      tick();
    end
    chk(nm, {31'd0, fifo_empty && !busy}, 1);
  endtask

  task automatic chk_seq(input string nm, input int base, input int n);
    chk({nm, "_len"}, acc_log.size(), n);
    for (int i = 0; i < n && i < acc_log.size(); i++)
      chk(nm, {24'd0, acc_log[i]}, 32'(8'(base + i)));
  endtask

  int base_ptr;
  int run;
  logic [7:0] hold;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    m_ready     = 1'b1;
    force_empty = 1'b0;

    // Reset with a non-empty FIFO, then stream 0..19
    load(0, 20);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_rd_en", {31'd0, fifo_rd_en}, 0);
      chk("reset_valid", {31'd0, m_valid}, 0);
      chk("reset_busy", {31'd0, busy}, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("stream_first_pop", {31'd0, fifo_rd_en}, 1);
    tick();
    chk("stream_lat1_valid", {31'd0, m_valid}, 0);
    tick();
    chk("stream_lat2_valid", {31'd0, m_valid}, 1);
    chk("stream_lat2_data", {24'd0, m_data}, 0);
    run = 0;
    for (int i = 0; i < 100; i++) begin
      if (!m_valid) break;
      run++;
      tick();
    end
    chk("stream_run", run, 20);
    wait_idle("stream_idle");
    chk("stream_cnt", {16'd0, word_cnt}, 20);
    chk_seq("stream_seq", 0, 20);

    // Back-pressure mid-stream
    do_reset();
    load(0, 10);
    base_ptr = rd_ptr;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    m_ready = 1'b0;
    hold = m_data;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_hold_valid", {31'd0, m_valid}, 1);
      chk("bp_hold_data", {24'd0, m_data}, {24'd0, hold});
    end
    chk("bp_credit", rd_ptr - base_ptr - acc_log.size(), 2);
    m_ready = 1'b1;
    wait_idle("bp_idle");
    chk_seq("bp_seq", 0, 10);

    // Empty FIFO, then drain two buffered words
    do_reset();
    force_empty = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("empty_rd_en", {31'd0, fifo_rd_en}, 0);
      chk("empty_valid", {31'd0, m_valid}, 0);
    end
    force_empty = 1'b0;
    m_ready = 1'b0;
    load(50, 2);
    for (int i = 0; i < 4; i++) tick();
    chk("empty_rd_en_after", {31'd0, fifo_rd_en}, 0);
    chk("empty_full_valid", {31'd0, m_valid}, 1);
    chk("empty_head", {24'd0, m_data}, 50);
    m_ready = 1'b1;
    tick();
    chk("empty_second", {24'd0, m_data}, 51);
    tick();
    chk("empty_valid_low", {31'd0, m_valid}, 0);
    chk("empty_busy_low", {31'd0, busy}, 0);

    // Enable dropped right after a pop
    do_reset();
    load(40, 5);
    m_ready = 1'b0;
    rst_n = 1'b1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #0;
      chk("en_no_pop", {31'd0, fifo_rd_en}, 0);
      tick();
    end
    chk("en_word_valid", {31'd0, m_valid}, 1);
    chk("en_word_data", {24'd0, m_data}, 40);
    m_ready = 1'b1;
    tick();
    enable = 1'b1;
    wait_idle("en_idle");
    chk_seq("en_seq", 40, 5);

    // Reset while the buffer holds two words
    do_reset();
    load(60, 6);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("mid_full_head", {24'd0, m_data}, 62);
    chk("mid_full_cnt", {16'd0, word_cnt}, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", {31'd0, fifo_rd_en}, 0);
    chk("mid_rst_valid", {31'd0, m_valid}, 0);
    chk("mid_rst_data", {24'd0, m_data}, 0);
    chk("mid_rst_cnt", {16'd0, word_cnt}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);

    // Counter wrap over 17 transfers
    do_reset();
    m_ready = 1'b1;
    load(100, 17);
    rst_n = 1'b1;
    tick();
    wait_idle("wrap_idle");
    chk("wrap_cnt16", {16'd0, word_cnt}, 17);
    chk("wrap_cnt4", {28'd0, word_cnt4}, 1);
    chk_seq("wrap_seq", 100, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
